mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5: number of busy cycles for a multiply.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10: number of busy cycles for a divide.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request strobe from the EX stage; sampled on the rising edge.
REQ-006 SHALL have port op  input  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu.
REQ-007 SHALL have port A  input  32  forwarded rs operand.
REQ-008 SHALL have port B  input  32  forwarded rt operand.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port HI  output  32  HI register, read by mfhi.
REQ-011 SHALL have port LO  output  32  LO register, read by mflo.

Function
REQ-012 SHALL accept start only when busy=0; start while busy=1 is ignored, and the operation in flight is unaffected.
REQ-013 SHALL latch op, A and B on the accepting edge; later changes to A/B SHALL NOT affect the result.
REQ-014 SHALL handle ops 4/5 (mthi/mtlo) in one edge: HI<=A or LO<=A respectively; busy stays 0.
REQ-015 SHALL implement the states IDLE and RUN with a down-counter: an accepted mult/multu/madd/maddu moves IDLE->RUN and loads MULT_CYCLES; an accepted div/divu moves IDLE->RUN and loads DIV_CYCLES.
REQ-016 SHALL drive busy=1 from the edge after acceptance for exactly the loaded number of cycles; on the edge where the counter reaches 1, the block SHALL write HI/LO, go to IDLE and drop busy.
REQ-017 SHALL allow a new start in the first cycle that busy=0 (back-to-back operation, no bubble cycle).
REQ-018 SHALL compute mult as the signed 64-bit product A*B, and multu as the unsigned product; HI = upper 32 bits, LO = lower 32 bits.
REQ-019 SHALL compute div as a signed divide: LO = quotient truncated toward zero, HI = remainder with the sign of A.
REQ-020 SHALL compute divu as an unsigned divide: LO = quotient, HI = remainder.
REQ-021 SHALL, when B=0 on div/divu, leave HI and LO unchanged while still running the full DIV_CYCLES busy period.
REQ-022 SHALL, for div with A=0x80000000 and B=0xFFFFFFFF, produce LO=0x80000000 and HI=0.
REQ-023 SHALL hold HI/LO stable during RUN; intermediate values SHALL NOT be visible on HI/LO.
REQ-024 SHALL size the counter as clog2(max(MULT_CYCLES,DIV_CYCLES))+1 bits; both parameters SHALL be >=1.

Reset
REQ-025 SHALL, on any edge where rst=0, set HI=0, LO=0, busy=0, counter=0 and state IDLE.
REQ-026 SHALL discard an operation in flight when reset is applied mid-RUN; no HI/LO write occurs.
REQ-027 SHALL ignore start in any cycle where rst=0.

Configuration
REQ-028 SHALL use macro MDU_MADD_EN to enable ops 6/7.
REQ-029 SHALL, with MDU_MADD_EN defined, compute madd as {HI,LO} <= {HI,LO} + signed(A*B) and maddu as {HI,LO} <= {HI,LO} + unsigned(A*B), both modulo 2^64, with MULT_CYCLES latency; the accumulate base is the {HI,LO} value at completion.
REQ-030 SHALL, without MDU_MADD_EN, treat ops 6/7 as no-ops: the start is accepted, busy stays 0, and HI/LO are unchanged.

Verification
REQ-031 SHALL cover this case: reset, then start op=0, A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-032 SHALL cover this case: start op=1, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles, HI=0xFFFFFFFE and LO=0x00000001.
REQ-033 SHALL cover this case: start op=2, A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF; repeat with B=0 -> busy for 10 cycles, HI/LO unchanged.
REQ-034 SHALL cover this case: start op=3 with start re-pulsed at busy cycle 4 using new operands -> the second request is ignored and the result matches the first operands only.
REQ-035 SHALL cover this case: start op=4, A=0x12345678 -> HI=0x12345678 on the next edge with busy=0; then a mult with rst=0 pulsed at busy cycle 3 -> HI=LO=0 and busy=0 on that edge.
REQ-036 SHALL cover this case, with MDU_MADD_EN defined: HI=0, LO=0xFFFFFFFF, then op=7, A=1, B=1 -> HI=1 and LO=0 after 5 cycles; without the macro -> busy stays 0 and HI/LO are unchanged.

Source files
------------

// File: rtl/mdu.sv
// mdu: multiply/divide unit with HI/LO result registers.
// A multiply or divide is latched on the accepting edge. It then runs for a fixed
// MULT_CYCLES or DIV_CYCLES busy period. HI/LO are written in one step at completion.
// Optional feature: define MDU_MADD_EN to enable op 6 (madd) and op 7 (maddu).
// With MDU_MADD_EN undefined, ops 6 and 7 are accepted as no-ops.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo complete here in one edge
// RUN   | multi-cycle op in flight; counter counts down to the write edge
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    // Both cycle parameters must be at least 1.
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [2:0]     op_q;
    logic [31:0]    a_q;
    logic [31:0]    b_q;

    logic [63:0]    prod_s;
    logic [63:0]    prod_u;
    logic [31:0]    b_safe;
    logic [31:0]    a_mag;
    logic [31:0]    b_mag;
    logic [31:0]    quo_u;
    logic [31:0]    rem_u;
    logic [31:0]    quo_m;
    logic [31:0]    rem_m;
    logic [31:0]    quo_s;
    logic [31:0]    rem_s;
    logic [63:0]    result;

    // Result of the latched operation, applied to HI/LO only on the completion edge.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        // A zero divisor never writes HI/LO; it is replaced here only to keep the
        // divider free of divide-by-zero.
        b_safe = (b_q == 32'd0) ? 32'd1 : b_q;
        quo_u  = a_q / b_safe;
        rem_u  = a_q % b_safe;
        // The signed divide is done on magnitudes, and the signs are then restored.
        // This makes 0x80000000 / -1 wrap to 0x80000000 with a zero remainder.
        a_mag  = a_q[31] ? (32'd0 - a_q) : a_q;
        b_mag  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
        quo_m  = a_mag / b_mag;
        rem_m  = a_mag % b_mag;
        quo_s  = (a_q[31] ^ b_safe[31]) ? (32'd0 - quo_m) : quo_m;
        rem_s  = a_q[31] ? (32'd0 - rem_m) : rem_m;
        result = {HI, LO};
        case (op_q)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   if (b_q != 32'd0) result = {rem_s, quo_s};
            OP_DIVU:  if (b_q != 32'd0) result = {rem_u, quo_u};
`ifdef MDU_MADD_EN
            OP_MADD:  result = {HI, LO} + prod_s;
            OP_MADDU: result = {HI, LO} + prod_u;
`endif
            default:  result = {HI, LO};
        endcase
    end

    // Sequencer: accepts requests in IDLE, and counts the busy period down in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        a_q  <= A;
                        b_q  <= B;
                        case (op)
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
`ifdef MDU_MADD_EN
                            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU: begin
`else
                            OP_MULT, OP_MULTU: begin
`endif
                                state <= RUN;
                                cnt   <= CW'(MULT_CYCLES);
                                busy  <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                state <= RUN;
                                cnt   <= CW'(DIV_CYCLES);
                                busy  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt == CW'(1)) begin
                        {HI, LO} <= result;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: the expected HI/LO and busy length of each request
// are pushed when the request is driven, and popped when the operation completes.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mhi;
    logic [31:0] mlo;

    always #5 clk = ~clk;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint          sa, sb_, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     tq, tr;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: return sa * sb_;
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sb_;
                r = sa % sb_;
                tq = q;
                tr = r;
                return {tr[31:0], tq[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {hi, lo};
                uq = ua / ub;
                ur = ua % ub;
                tq = uq;
                tr = ur;
                return {tr[31:0], tq[31:0]};
            end
            3'd4: return {a, lo};
            3'd5: return {hi, a};
`ifdef MDU_MADD_EN
            3'd6: return {hi, lo} + 64'(sa * sb_);
            3'd7: return {hi, lo} + 64'(ua * ub);
`endif
            default: return {hi, lo};
        endcase
    endfunction

    function automatic int model_cycles(input logic [2:0] o);
        case (o)
            3'd0, 3'd1: return 5;
            3'd2, 3'd3: return 10;
`ifdef MDU_MADD_EN
            3'd6, 3'd7: return 5;
`endif
            default: return 0;
        endcase
    endfunction

    // Drive one request at the current negedge, optionally re-pulse start at busy
    // cycle repulse_at, then wait for completion and score against the queue head.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int repulse_at = -1);
        exp_t        e;
        logic [63:0] r;
        int          n;
        r = model(o, a, b, mhi, mlo);
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.cyc = model_cycles(o);
        sb.push_back(e);
        {mhi, mlo} = r;
        start = 1'b1;
        op = o;
        A = a;
        B = b;
        @(negedge clk);
        start = 1'b0;
        A = ~a;
        B = ~b;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == repulse_at) begin
                start = 1'b1;
                A = 32'h0000_1234;
                B = 32'h0000_0007;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        e = sb.pop_front();
        chk({tag, "_busy_cycles"}, 64'(n), 64'(e.cyc));
        chk({tag, "_hi"}, {32'd0, HI}, {32'd0, e.hi});
        chk({tag, "_lo"}, {32'd0, LO}, {32'd0, e.lo});
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        op = 3'd0;
        A = 32'd0;
        B = 32'd0;
        mhi = 32'd0;
        mlo = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hi", {32'd0, HI}, 64'd0);
        chk("reset_lo", {32'd0, LO}, 64'd0);
        rst = 1'b1;

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("div_by0", 3'd2, 32'hFFFF_FFF9, 32'd0);
        run_op("divu_by0", 3'd3, 32'h1234_5678, 32'd0);
        run_op("divu_repulse", 3'd3, 32'd1000, 32'd7, 4);
        @(negedge clk);
        chk("repulse_no_second_op", {63'd0, busy}, 64'd0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_pos_neg", 3'd2, 32'd7, 32'hFFFF_FFFE);
        run_op("mthi", 3'd4, 32'h1234_5678, 32'd0);
        run_op("mtlo", 3'd5, 32'h9ABC_DEF0, 32'd0);

        // Reset at busy cycle 3 of a multiply; start during reset must also be ignored.
        start = 1'b1;
        op = 3'd0;
        A = 32'd5;
        B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b0;
        start = 1'b1;
        op = 3'd4;
        A = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_hi", {32'd0, HI}, 64'd0);
        chk("rst_mid_lo", {32'd0, LO}, 64'd0);
        rst = 1'b1;
        start = 1'b0;
        mhi = 32'd0;
        mlo = 32'd0;
        repeat (6) @(negedge clk);
        chk("rst_no_late_write_hi", {32'd0, HI}, 64'd0);
        chk("rst_no_late_write_lo", {32'd0, LO}, 64'd0);

        run_op("pre_madd_hi", 3'd4, 32'd0, 32'd0);
        run_op("pre_madd_lo", 3'd5, 32'hFFFF_FFFF, 32'd0);
        run_op("maddu", 3'd7, 32'd1, 32'd1);
        run_op("madd", 3'd6, 32'hFFFF_FFFF, 32'd3);

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ((i[0]) ? $urandom : 32'($urandom_range(1, 300)));
            run_op("rand", ro, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
